// File: rtl/crono_valor_cuenta_if.sv
// Handshake bundle between the chronometer field selector/controls and the
// chronometer value/countdown block.
interface crono_valor_cuenta_if;
    logic       sw_crono;
    logic       a_cr_hora;
    logic       a_cr_min;
    logic       a_cr_seg;
    logic       inc;
    logic       dec;
    logic       start;
    logic       stop;
    logic       tick_1hz;
    logic [7:0] hh_bcd;
    logic [7:0] mm_bcd;
    logic [7:0] ss_bcd;
    logic       running;
    logic       done;
    logic       done_pulse;

    modport master (
        output sw_crono, a_cr_hora, a_cr_min, a_cr_seg, inc, dec, start, stop, tick_1hz,
        input  hh_bcd, mm_bcd, ss_bcd, running, done, done_pulse
    );

    modport slave (
        input  sw_crono, a_cr_hora, a_cr_min, a_cr_seg, inc, dec, start, stop, tick_1hz,
        output hh_bcd, mm_bcd, ss_bcd, running, done, done_pulse
    );
endinterface

// File: rtl/crono_valor_cuenta.sv
// Chronometer preset hh:mm:ss held in BCD, adjustable in IDLE and counted down once per
// second in RUN, with a level alarm and a one-cycle alarm pulse at 00:00:00.
module crono_valor_cuenta #(
    parameter int unsigned HOUR_MAX   = 23,
    parameter int unsigned MINSEC_MAX = 59
) (
    input logic                  clk,
    input logic                  rst,
    crono_valor_cuenta_if.slave  bus
);

    localparam logic [7:0] HourMaxBcd   = {4'(HOUR_MAX / 10), 4'(HOUR_MAX % 10)};
    localparam logic [7:0] MinsecMaxBcd = {4'(MINSEC_MAX / 10), 4'(MINSEC_MAX % 10)};

    typedef enum logic [1:0] {StIdle, StRun, StPause, StDone} state_e;

    state_e     state_q;
    logic [7:0] hh_q, mm_q, ss_q;
    logic       running_q, done_q, done_pulse_q;

    logic [7:0] hh_dn, mm_dn, ss_dn;
    logic       val_zero, dn_zero;
    logic       adj;

    function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] max);
        if (v == max)              return 8'h00;
        else if (v[3:0] == 4'd9)   return {v[7:4] + 4'd1, 4'd0};
        else                       return {v[7:4], v[3:0] + 4'd1};
    endfunction

    function automatic logic [7:0] bcd_dec(input logic [7:0] v, input logic [7:0] max);
        if (v == 8'h00)            return max;
        else if (v[3:0] == 4'd0)   return {v[7:4] - 4'd1, 4'd9};
        else                       return {v[7:4], v[3:0] - 4'd1};
    endfunction

    // One-second-earlier value; borrows ripple only through fields that are 00.
    always_comb begin
        ss_dn = bcd_dec(ss_q, MinsecMaxBcd);
        mm_dn = mm_q;
        hh_dn = hh_q;
        if (ss_q == 8'h00) begin
            mm_dn = bcd_dec(mm_q, MinsecMaxBcd);
            if (mm_q == 8'h00) hh_dn = bcd_dec(hh_q, HourMaxBcd);
        end
        val_zero = ({hh_q, mm_q, ss_q} == 24'h0);
        dn_zero  = ({hh_dn, mm_dn, ss_dn} == 24'h0);
        adj      = bus.sw_crono & (bus.inc ^ bus.dec);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            hh_q         <= 8'h00;
            mm_q         <= 8'h00;
            ss_q         <= 8'h00;
            running_q    <= 1'b0;
            done_q       <= 1'b0;
            done_pulse_q <= 1'b0;
        end else begin
            done_pulse_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (bus.start && !bus.stop && !bus.sw_crono && !val_zero) begin
                        state_q   <= StRun;
                        running_q <= 1'b1;
                    end else if (adj) begin
                        if (bus.a_cr_hora) begin
                            hh_q <= bus.inc ? bcd_inc(hh_q, HourMaxBcd) : bcd_dec(hh_q, HourMaxBcd);
                        end else if (bus.a_cr_min) begin
                            mm_q <= bus.inc ? bcd_inc(mm_q, MinsecMaxBcd)
                                            : bcd_dec(mm_q, MinsecMaxBcd);
                        end else if (bus.a_cr_seg) begin
                            ss_q <= bus.inc ? bcd_inc(ss_q, MinsecMaxBcd)
                                            : bcd_dec(ss_q, MinsecMaxBcd);
                        end
                    end
                end
                StRun: begin
                    if (bus.stop) begin
                        state_q   <= StPause;
                        running_q <= 1'b0;
                    end else if (bus.tick_1hz) begin
                        hh_q <= hh_dn;
                        mm_q <= mm_dn;
                        ss_q <= ss_dn;
                        if (dn_zero) begin
                            state_q      <= StDone;
                            running_q    <= 1'b0;
                            done_q       <= 1'b1;
                            done_pulse_q <= 1'b1;
                        end
                    end
                end
                StPause: begin
                    if (bus.stop) begin
                        state_q <= StIdle;
                    end else if (bus.start) begin
                        state_q   <= StRun;
                        running_q <= 1'b1;
                    end
                end
                StDone: begin
                    if (bus.start || bus.stop) begin
                        state_q <= StIdle;
                        done_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q   <= StIdle;
                    running_q <= 1'b0;
                    done_q    <= 1'b0;
                end
            endcase
        end
    end

    assign bus.hh_bcd     = hh_q;
    assign bus.mm_bcd     = mm_q;
    assign bus.ss_bcd     = ss_q;
    assign bus.running    = running_q;
    assign bus.done       = done_q;
    assign bus.done_pulse = done_pulse_q;

endmodule
